ram_arbiter: RTL and testbench

- Two-master round-robin arbiter and sequencer in front of the single-port word RAM.
- The RAM has a combinational read and a synchronous full-word write only. This block adds byte-enable writes by running a two-cycle read-modify-write for partial writes.
- It returns a registered response to each master.
- Typical masters: m0 = core data port, m1 = debug/DMA port.

---
 rtl/ram_arbiter.sv | 157 +++++++++++++++
 tb/tb_ram_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Two-master round-robin arbiter in front of a single-port word RAM.
// Partial byte-enable writes become a two-cycle read-modify-write.
module ram_arbiter #(
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32,
    localparam int BeWidth  = DataWidth / 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,

    input  logic                 m0_req_i,
    input  logic                 m0_we_i,
    input  logic [AddrWidth-1:0] m0_addr_i,
    input  logic [BeWidth-1:0]   m0_be_i,
    input  logic [DataWidth-1:0] m0_wdata_i,
    output logic                 m0_gnt_o,
    output logic                 m0_rvalid_o,
    output logic [DataWidth-1:0] m0_rdata_o,

    input  logic                 m1_req_i,
    input  logic                 m1_we_i,
    input  logic [AddrWidth-1:0] m1_addr_i,
    input  logic [BeWidth-1:0]   m1_be_i,
    input  logic [DataWidth-1:0] m1_wdata_i,
    output logic                 m1_gnt_o,
    output logic                 m1_rvalid_o,
    output logic [DataWidth-1:0] m1_rdata_o,

    output logic                 ram_we_o,
    output logic [AddrWidth-1:0] ram_addr_o,
    output logic [DataWidth-1:0] ram_wdata_o,
    input  logic [DataWidth-1:0] ram_rdata_i
);

    typedef enum logic {IDLE, RMW} state_e;

    state_e                 state_q, state_d;
    logic                   last_gnt_q;
    logic                   gnt0, gnt1, gnt_any;

    logic                   sel_we;
    logic [AddrWidth-1:0]   sel_addr;
    logic [BeWidth-1:0]     sel_be;
    logic [DataWidth-1:0]   sel_wdata;
    logic                   be_full, be_none, sel_partial;
    logic                   rmw_done;

    logic [AddrWidth-1:0]   rmw_addr_p1;
    logic [BeWidth-1:0]     rmw_be_p1;
    logic [DataWidth-1:0]   rmw_wdata_p1;
    logic [DataWidth-1:0]   rmw_old_p1;
    logic                   rmw_owner_p1;

    logic                   m0_vld_p1, m1_vld_p1;
    logic [DataWidth-1:0]   m0_rdata_p1, m1_rdata_p1;

    function automatic logic [DataWidth-1:0] merge_bytes(
        input logic [DataWidth-1:0] old_w,
        input logic [DataWidth-1:0] new_w,
        input logic [BeWidth-1:0]   be
    );
        logic [DataWidth-1:0] m;
        m = old_w;
        for (int i = 0; i < BeWidth; i++) begin
            if (be[i]) m[8*i +: 8] = new_w[8*i +: 8];
        end
        return m;
    endfunction

    // last_gnt_q = 1 means m1 was granted last, so m0 wins the next tie.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state_q == IDLE) begin
            if (m0_req_i && (!m1_req_i || last_gnt_q)) gnt0 = 1'b1;
            else if (m1_req_i)                        gnt1 = 1'b1;
        end
    end

    assign gnt_any   = gnt0 | gnt1;
    assign sel_we    = gnt1 ? m1_we_i    : m0_we_i;
    assign sel_addr  = gnt1 ? m1_addr_i  : m0_addr_i;
    assign sel_be    = gnt1 ? m1_be_i    : m0_be_i;
    assign sel_wdata = gnt1 ? m1_wdata_i : m0_wdata_i;

    assign be_full     = &sel_be;
    assign be_none     = (sel_be == '0);
    assign sel_partial = gnt_any && sel_we && !be_full && !be_none;
    assign rmw_done    = (state_q == RMW);

    always_comb begin
        state_d     = state_q;
        ram_we_o    = 1'b0;
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    ram_addr_o = sel_addr;
                    if (sel_we && be_full) begin
                        ram_we_o    = 1'b1;
                        ram_wdata_o = sel_wdata;
                    end
                    if (sel_partial) state_d = RMW;
                end
            end
            RMW: begin
                ram_we_o    = 1'b1;
                ram_addr_o  = rmw_addr_p1;
                ram_wdata_o = merge_bytes(rmw_old_p1, rmw_wdata_p1, rmw_be_p1);
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // p1: grant-cycle capture; responses and RMW operands become visible next cycle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            last_gnt_q   <= 1'b1;
            rmw_addr_p1  <= '0;
            rmw_be_p1    <= '0;
            rmw_wdata_p1 <= '0;
            rmw_old_p1   <= '0;
            rmw_owner_p1 <= 1'b0;
            m0_vld_p1    <= 1'b0;
            m1_vld_p1    <= 1'b0;
            m0_rdata_p1  <= '0;
            m1_rdata_p1  <= '0;
        end else begin
            state_q <= state_d;
            if (gnt_any) last_gnt_q <= gnt1;
            if (sel_partial) begin
                rmw_addr_p1  <= sel_addr;
                rmw_be_p1    <= sel_be;
                rmw_wdata_p1 <= sel_wdata;
                rmw_old_p1   <= ram_rdata_i;
                rmw_owner_p1 <= gnt1;
            end
            m0_vld_p1 <= (gnt0 && !sel_partial) || (rmw_done && !rmw_owner_p1);
            m1_vld_p1 <= (gnt1 && !sel_partial) || (rmw_done &&  rmw_owner_p1);
            if (gnt0 && !sel_partial)          m0_rdata_p1 <= sel_we ? '0 : ram_rdata_i;
            else if (rmw_done && !rmw_owner_p1) m0_rdata_p1 <= '0;
            if (gnt1 && !sel_partial)          m1_rdata_p1 <= sel_we ? '0 : ram_rdata_i;
            else if (rmw_done && rmw_owner_p1)  m1_rdata_p1 <= '0;
        end
    end

    assign m0_gnt_o    = gnt0;
    assign m1_gnt_o    = gnt1;
    assign m0_rvalid_o = m0_vld_p1;
    assign m1_rvalid_o = m1_vld_p1;
    assign m0_rdata_o  = m0_rdata_p1;
    assign m1_rdata_o  = m1_rdata_p1;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: vector table for arbitration plus
// hand sequences for RMW and reset, with a per-master response scoreboard.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        preload;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_be, m1_be;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        ram_we;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [31:0] mem     [0:63];
    logic [31:0] ref_mem [0:63];

    typedef struct {
        logic [31:0] data;
        int          due;
    } rsp_t;
    rsp_t q0[$];
    rsp_t q1[$];

    typedef struct {
        logic        r0, r1, we0;
        logic [31:0] a0, a1;
        logic [3:0]  be0;
        logic [31:0] wd0;
        logic        eg0, eg1, ewe;
        logic [31:0] eaddr, ewd;
    } vec_t;
    vec_t tbl [9];

    ram_arbiter dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .m0_req_i   (m0_req),
        .m0_we_i    (m0_we),
        .m0_addr_i  (m0_addr),
        .m0_be_i    (m0_be),
        .m0_wdata_i (m0_wdata),
        .m0_gnt_o   (m0_gnt),
        .m0_rvalid_o(m0_rvalid),
        .m0_rdata_o (m0_rdata),
        .m1_req_i   (m1_req),
        .m1_we_i    (m1_we),
        .m1_addr_i  (m1_addr),
        .m1_be_i    (m1_be),
        .m1_wdata_i (m1_wdata),
        .m1_gnt_o   (m1_gnt),
        .m1_rvalid_o(m1_rvalid),
        .m1_rdata_o (m1_rdata),
        .ram_we_o   (ram_we),
        .ram_addr_o (ram_addr),
        .ram_wdata_o(ram_wdata),
        .ram_rdata_i(ram_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(input int i);
        return (i == 2 || i == 4) ? 32'h1122_3344 : (32'hA500_0000 | i);
    endfunction

    // Behavioural RAM: combinational read, synchronous full-word write
    assign ram_rdata = mem[ram_addr[7:2]];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
        end else if (ram_we) begin
            mem[ram_addr[7:2]] <= ram_wdata;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic check_rsp(input bit m, input logic [31:0] got);
        rsp_t e;
        total++;
        if ((m ? q1.size() : q0.size()) == 0) begin
            bad++;
            $display("FAIL rvalid_m%0d: unexpected response rdata=%h at cycle %0d", m, got, cyc);
        end else begin
            e = m ? q1.pop_front() : q0.pop_front();
            if (got !== e.data || cyc != e.due) begin
                bad++;
                $display("FAIL rsp_m%0d: got rdata=%h at cycle %0d, expected rdata=%h at cycle %0d",
                         m, got, cyc, e.data, e.due);
            end
        end
    endtask

    task automatic on_grant(input bit m, input logic we, input logic [31:0] addr,
                            input logic [3:0] be, input logic [31:0] wd);
        rsp_t e;
        int   idx;
        bit   part;
        idx  = int'(addr[7:2]);
        part = we && (be != 4'h0) && (be != 4'hF);
        e.due = cyc + (part ? 2 : 1);
        if (!we) begin
            e.data = ref_mem[idx];
        end else begin
            e.data = 32'h0;
            for (int b = 0; b < 4; b++)
                if (be[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
        end
        if (m) q1.push_back(e);
        else   q0.push_back(e);
    endtask

    // Scoreboard monitor: push on grant, pop on rvalid
    always @(negedge clk) begin
        if (m0_rvalid) check_rsp(1'b0, m0_rdata);
        if (m1_rvalid) check_rsp(1'b1, m1_rdata);
        if (m0_gnt || m1_gnt) begin
            total++;
            if (m0_gnt && m1_gnt) begin
                bad++;
                $display("FAIL gnt_onehot: got m0_gnt=1 m1_gnt=1 expected at most one at cycle %0d", cyc);
            end
        end
        if (m0_gnt) on_grant(1'b0, m0_we, m0_addr, m0_be, m0_wdata);
        else if (m1_gnt) on_grant(1'b1, m1_we, m1_addr, m1_be, m1_wdata);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_be = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_be = 0; m1_wdata = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] saved;
        //            r0 r1 we0 a0        a1        be0   wd0           eg0 eg1 ewe eaddr     ewd
        tbl[0] = '{1'b0,1'b0,1'b0,32'h00,32'h00,4'h0,32'h0,        1'b0,1'b0,1'b0,32'h00,32'h0};
        tbl[1] = '{1'b1,1'b0,1'b0,32'h10,32'h00,4'h0,32'h0,        1'b1,1'b0,1'b0,32'h10,32'h0};
        tbl[2] = '{1'b1,1'b1,1'b0,32'h20,32'h14,4'h0,32'h0,        1'b0,1'b1,1'b0,32'h14,32'h0};
        tbl[3] = '{1'b1,1'b1,1'b0,32'h18,32'h24,4'h0,32'h0,        1'b1,1'b0,1'b0,32'h18,32'h0};
        tbl[4] = '{1'b0,1'b1,1'b0,32'h00,32'h1C,4'h0,32'h0,        1'b0,1'b1,1'b0,32'h1C,32'h0};
        tbl[5] = '{1'b1,1'b0,1'b1,32'h04,32'h00,4'hF,32'hDEADBEEF, 1'b1,1'b0,1'b1,32'h04,32'hDEADBEEF};
        tbl[6] = '{1'b1,1'b1,1'b0,32'h20,32'h04,4'h0,32'h0,        1'b0,1'b1,1'b0,32'h04,32'h0};
        tbl[7] = '{1'b1,1'b0,1'b1,32'h10,32'h00,4'h0,32'hCAFEF00D, 1'b1,1'b0,1'b0,32'h10,32'h0};
        tbl[8] = '{1'b0,1'b0,1'b0,32'h00,32'h00,4'h0,32'h0,        1'b0,1'b0,1'b0,32'h00,32'h0};

        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        idle_inputs();
        rst_n   = 0;
        preload = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_m0_gnt",    {31'h0, m0_gnt},    32'h0);
        chk("rst_m1_gnt",    {31'h0, m1_gnt},    32'h0);
        chk("rst_m0_rvalid", {31'h0, m0_rvalid}, 32'h0);
        chk("rst_m1_rvalid", {31'h0, m1_rvalid}, 32'h0);
        chk("rst_m0_rdata",  m0_rdata,           32'h0);
        chk("rst_m1_rdata",  m1_rdata,           32'h0);
        chk("rst_ram_we",    {31'h0, ram_we},    32'h0);
        chk("rst_ram_addr",  ram_addr,           32'h0);
        chk("rst_ram_wdata", ram_wdata,          32'h0);
        @(posedge clk);
        #1;
        preload = 0;
        rst_n   = 1;

        // Arbitration / single-cycle transaction table
        for (int i = 0; i < 9; i++) begin
            m0_req = tbl[i].r0; m0_we = tbl[i].we0; m0_addr = tbl[i].a0;
            m0_be  = tbl[i].be0; m0_wdata = tbl[i].wd0;
            m1_req = tbl[i].r1; m1_we = 1'b0; m1_addr = tbl[i].a1;
            m1_be  = 4'h0; m1_wdata = 32'h0;
            @(negedge clk);
            chk($sformatf("vec%0d_m0_gnt", i), {31'h0, m0_gnt}, {31'h0, tbl[i].eg0});
            chk($sformatf("vec%0d_m1_gnt", i), {31'h0, m1_gnt}, {31'h0, tbl[i].eg1});
            chk($sformatf("vec%0d_ram_we", i), {31'h0, ram_we}, {31'h0, tbl[i].ewe});
            chk($sformatf("vec%0d_ram_addr", i), ram_addr, tbl[i].eaddr);
            if (tbl[i].ewe) chk($sformatf("vec%0d_ram_wdata", i), ram_wdata, tbl[i].ewd);
            step();
        end
        idle_inputs();
        repeat (3) step();

        // Both masters hold reads: grants alternate starting with m0
        do_reset();
        m0_req = 1; m0_addr = 32'h10;
        m1_req = 1; m1_addr = 32'h14;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("rr%0d_m0_gnt", i), {31'h0, m0_gnt}, (i % 2 == 0) ? 32'h1 : 32'h0);
            chk($sformatf("rr%0d_m1_gnt", i), {31'h0, m1_gnt}, (i % 2 == 1) ? 32'h1 : 32'h0);
            step();
        end
        idle_inputs();
        repeat (3) step();

        // m1 partial write with m0 waiting behind the RMW cycle
        do_reset();
        m1_req = 1; m1_we = 1; m1_addr = 32'h8; m1_be = 4'b0101; m1_wdata = 32'hAABBCCDD;
        @(negedge clk);
        chk("rmw_t_m1_gnt", {31'h0, m1_gnt}, 32'h1);
        chk("rmw_t_ram_we", {31'h0, ram_we}, 32'h0);
        chk("rmw_t_ram_addr", ram_addr, 32'h8);
        step();
        idle_inputs();
        m0_req = 1; m0_addr = 32'h10;
        @(negedge clk);
        chk("rmw_t1_m0_gnt", {31'h0, m0_gnt}, 32'h0);
        chk("rmw_t1_m1_gnt", {31'h0, m1_gnt}, 32'h0);
        chk("rmw_t1_ram_we", {31'h0, ram_we}, 32'h1);
        chk("rmw_t1_ram_addr", ram_addr, 32'h8);
        chk("rmw_t1_ram_wdata", ram_wdata, 32'h11BB33DD);
        step();
        @(negedge clk);
        chk("rmw_t2_m0_gnt", {31'h0, m0_gnt}, 32'h1);
        chk("rmw_t2_m1_rvalid", {31'h0, m1_rvalid}, 32'h1);
        step();
        idle_inputs();
        repeat (3) step();

        // Reset asserted during the RMW cycle
        do_reset();
        saved  = ref_mem[3];
        m0_req = 1; m0_we = 1; m0_addr = 32'hC; m0_be = 4'b0011; m0_wdata = 32'h12345678;
        @(negedge clk);
        chk("abort_t_m0_gnt", {31'h0, m0_gnt}, 32'h1);
        step();
        idle_inputs();
        #1;
        rst_n = 0;
        @(negedge clk);
        q0.delete();
        ref_mem[3] = saved;
        chk("abort_ram_we",    {31'h0, ram_we},    32'h0);
        chk("abort_ram_addr",  ram_addr,           32'h0);
        chk("abort_ram_wdata", ram_wdata,          32'h0);
        chk("abort_m0_rvalid", {31'h0, m0_rvalid}, 32'h0);
        chk("abort_m1_rvalid", {31'h0, m1_rvalid}, 32'h0);
        chk("abort_m0_rdata",  m0_rdata,           32'h0);
        step();
        rst_n = 1;
        m0_req = 1; m0_addr = 32'h10;
        m1_req = 1; m1_addr = 32'h14;
        @(negedge clk);
        chk("post_abort_m0_gnt", {31'h0, m0_gnt}, 32'h1);
        chk("post_abort_m1_gnt", {31'h0, m1_gnt}, 32'h0);
        step();
        idle_inputs();
        repeat (4) step();

        chk("q0_drained", q0.size(), 32'h0);
        chk("q1_drained", q1.size(), 32'h0);
        for (int i = 0; i < 64; i++) chk($sformatf("mem[%0d]", i), mem[i], ref_mem[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
